// File: rtl/wdt_kick_ctrl.sv
// Bus-side watchdog controller: holds PERIOD/RSTLEN, gates kicks behind a two-word key,
// freezes the watchdog while disabled, and stretches the watchdog reset into a CPU reset.
module wdt_kick_ctrl #(
  parameter logic [31:0] KEY1        = 32'h0000_5555,
  parameter logic [31:0] KEY2        = 32'h0000_AAAA,
  parameter int unsigned KEY_WIN     = 16,
  parameter int unsigned RST_STRETCH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  input  logic        i_fail_safe,
  input  logic        i_hw_rst,
  output logic        o_clrwdt,
  output logic [31:0] o_wait_period,
  output logic        o_wait_w_en,
  output logic [31:0] o_rst_period,
  output logic        o_cpu_rst,
  output logic        o_key_err
);

  localparam int unsigned WIN_W = $clog2(KEY_WIN + 1);
  localparam int unsigned STR_W = $clog2(RST_STRETCH + 1);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_KEY1, S_RST} state_t;

  state_t             state;
  logic               en;
  logic               lock;
  logic               fs_sticky;
  logic               hw_q;
  logic [31:0]        period;
  logic [31:0]        rstlen;
  logic [15:0]        rst_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [STR_W-1:0]   str_cnt;
  logic [31:0]        rd_mux;
  logic               bus_wr;
  logic               ctrl_wr;
  logic               key_wr;
  logic               en_off;

  // The watchdog reset and the S_RST state both shut out the bus.
  assign bus_wr  = i_we && !i_hw_rst && (state != S_RST);
  assign ctrl_wr = bus_wr && (i_addr == 2'd0);
  assign key_wr  = bus_wr && (i_addr == 2'd3);
  assign en_off  = ctrl_wr && !i_wdata[0] && !lock;

  assign o_wait_period = period;
  assign o_rst_period  = rstlen;

  always_comb begin
    rd_mux = '0;
    case (i_addr)
      2'd0:    rd_mux = {rst_cnt, 12'b0, fs_sticky, i_hw_rst, lock, en};
      2'd1:    rd_mux = period;
      2'd2:    rd_mux = rstlen;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_OFF;
      en          <= 1'b0;
      lock        <= 1'b0;
      fs_sticky   <= 1'b0;
      hw_q        <= 1'b0;
      period      <= 32'd1000;
      rstlen      <= 32'd10;
      rst_cnt     <= '0;
      win_cnt     <= '0;
      str_cnt     <= '0;
      o_rdata     <= '0;
      o_clrwdt    <= 1'b1;
      o_wait_w_en <= 1'b0;
      o_cpu_rst   <= 1'b0;
      o_key_err   <= 1'b0;
    end else begin
      o_key_err <= 1'b0;
      hw_q      <= i_hw_rst;
      if (i_re) o_rdata <= rd_mux;

      if (i_fail_safe)               fs_sticky <= 1'b1;
      else if (ctrl_wr && i_wdata[2]) fs_sticky <= 1'b0;

      // Register file; LOCK is sticky and freezes the timing configuration.
      if (ctrl_wr) begin
        lock <= lock | i_wdata[1];
        if (i_wdata[0] || !lock) en <= i_wdata[0];
        else                     o_key_err <= 1'b1;
      end
      if (bus_wr && (i_addr == 2'd1)) begin
        if (!lock) period <= i_wdata;
        else       o_key_err <= 1'b1;
      end
      if (bus_wr && (i_addr == 2'd2)) begin
        if (!lock) rstlen <= i_wdata;
        else       o_key_err <= 1'b1;
      end

      if (i_hw_rst) begin
        state       <= S_RST;
        o_cpu_rst   <= 1'b1;
        o_clrwdt    <= 1'b0;
        o_wait_w_en <= 1'b0;
        str_cnt     <= STR_W'(RST_STRETCH);
        if (!hw_q && (rst_cnt != 16'hFFFF)) rst_cnt <= rst_cnt + 16'd1;
      end else begin
        case (state)
          S_OFF: begin
            if (ctrl_wr && i_wdata[0]) begin
              state       <= S_RUN;
              o_clrwdt    <= 1'b0;
              o_wait_w_en <= 1'b0;
            end else begin
              o_clrwdt    <= 1'b1;
              o_wait_w_en <= 1'b1;
            end
          end
          S_RUN: begin
            o_clrwdt    <= 1'b0;
            o_wait_w_en <= 1'b0;
            if (en_off) begin
              state       <= S_OFF;
              o_clrwdt    <= 1'b1;
              o_wait_w_en <= 1'b1;
            end else if (key_wr) begin
              if (i_wdata == KEY1) begin
                state   <= S_KEY1;
                win_cnt <= WIN_W'(KEY_WIN);
              end else begin
                o_key_err <= 1'b1;
              end
            end
          end
          S_KEY1: begin
            o_clrwdt    <= 1'b0;
            o_wait_w_en <= 1'b0;
            win_cnt     <= win_cnt - WIN_W'(1);
            if (en_off) begin
              state       <= S_OFF;
              o_clrwdt    <= 1'b1;
              o_wait_w_en <= 1'b1;
            end else if (key_wr) begin
              state <= S_RUN;
              if (i_wdata == KEY2) begin
                o_clrwdt    <= 1'b1;
                o_wait_w_en <= 1'b1;
              end else begin
                o_key_err <= 1'b1;
              end
            end else if (win_cnt == WIN_W'(1)) begin
              // Last cycle of the window passed without KEY2.
              state     <= S_RUN;
              o_key_err <= 1'b1;
            end
          end
          S_RST: begin
            if (str_cnt == '0) begin
              o_cpu_rst   <= 1'b0;
              state       <= en ? S_RUN : S_OFF;
              o_clrwdt    <= !en;
              o_wait_w_en <= !en;
            end else begin
              str_cnt <= str_cnt - STR_W'(1);
            end
          end
          default: state <= S_OFF;
        endcase
      end
    end
  end

endmodule
